// File: rtl/id_fwd_scoreboard_pkg.sv
// Shared types and constants for the ID-stage forwarding scoreboard.
// Optional counters are enabled by defining FWD_STALL_CNT_EN.
package id_fwd_scoreboard_pkg;

    localparam int DEF_REG_AW = 5;
    localparam int DEF_DEPTH  = 3;
    localparam int DEF_NUM_RD = 2;

    localparam int SEL_RF   = 0;
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    localparam int CNT_W = 32;

    // Select/latency width: enough to encode "register file" plus every tracked stage.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_SEL_W = sel_width(DEF_DEPTH);

    typedef struct packed {
        logic                  vld;
        logic [DEF_REG_AW-1:0] dest;
        logic [DEF_SEL_W-1:0]  lat;
    } def_entry_t;

endpackage

// File: rtl/id_fwd_scoreboard_match.sv
// Per-read-port youngest-producer search and result-ready check.
module fwd_port_match
    import id_fwd_scoreboard_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SEL_W  = sel_width(DEPTH)
) (
    input  logic [REG_AW-1:0]             rd_addr_i,
    input  logic                          rd_used_i,
    input  logic [DEPTH-1:0]              ent_vld_i,
    input  logic [DEPTH-1:0][REG_AW-1:0]  ent_dest_i,
    input  logic [DEPTH-1:0][SEL_W-1:0]   ent_lat_i,
    output logic [SEL_W-1:0]              fwd_sel_o,
    output logic                          unready_o
);

    logic             found;
    logic [SEL_W-1:0] hitStage;
    logic [SEL_W-1:0] hitLat;

    // Lowest stage index is the youngest producer; older matches are ignored.
    always_comb begin
        found    = 1'b0;
        hitStage = '0;
        hitLat   = '0;
        if (rd_used_i && (rd_addr_i != '0)) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (!found && ent_vld_i[s] && (ent_dest_i[s] == rd_addr_i)) begin
                    found    = 1'b1;
                    hitStage = SEL_W'(s + 1);
                    hitLat   = ent_lat_i[s];
                end
            end
        end
    end

    always_comb begin
        fwd_sel_o = SEL_W'(SEL_RF);
        unready_o = 1'b0;
        if (found) begin
            if (hitStage >= hitLat) begin
                fwd_sel_o = hitStage;
            end else begin
                unready_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// ID-stage forwarding scoreboard: shift register of in-flight destinations, per-port
// forward selects and load-use style stall. Define FWD_STALL_CNT_EN for the counters.
module id_fwd_scoreboard
    import id_fwd_scoreboard_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int SEL_W  = sel_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NUM_RD*REG_AW-1:0] id_rd_addr,
    input  logic [NUM_RD-1:0]        id_rd_used,
    input  logic                     id_wr_en,
    input  logic [REG_AW-1:0]        id_dest,
    input  logic [SEL_W-1:0]         id_lat,
    input  logic                     pipe_hold,
    output logic [NUM_RD*SEL_W-1:0]  fwd_sel,
    output logic                     stall,
    output logic                     id_issue
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         fwd_hit_cnt
`endif
);

    logic [DEPTH-1:0]             vld_q,  vld_d;
    logic [DEPTH-1:0][REG_AW-1:0] dest_q, dest_d;
    logic [DEPTH-1:0][SEL_W-1:0]  lat_q,  lat_d;

    logic [NUM_RD-1:0] portUnready;
    logic [SEL_W-1:0]  latNorm;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        fwd_port_match #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_match (
            .rd_addr_i  (id_rd_addr[i*REG_AW +: REG_AW]),
            .rd_used_i  (id_rd_used[i]),
            .ent_vld_i  (vld_q),
            .ent_dest_i (dest_q),
            .ent_lat_i  (lat_q),
            .fwd_sel_o  (fwd_sel[i*SEL_W +: SEL_W]),
            .unready_o  (portUnready[i])
        );
    end

    assign stall    = id_valid && (|portUnready);
    assign id_issue = id_valid && !stall && !pipe_hold;

    // A zero latency means "ready out of EX"; anything past the last stage clamps to it.
    always_comb begin
        latNorm = id_lat;
        if (id_lat == '0) begin
            latNorm = SEL_W'(LAT_ALU);
        end else if (int'(id_lat) > DEPTH) begin
            latNorm = SEL_W'(DEPTH);
        end
    end

    // Stalled or non-writing cycles push a bubble, so waiting producers keep moving.
    always_comb begin
        vld_d  = vld_q;
        dest_d = dest_q;
        lat_d  = lat_q;
        if (!pipe_hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                vld_d[k]  = vld_q[k-1];
                dest_d[k] = dest_q[k-1];
                lat_d[k]  = lat_q[k-1];
            end
            vld_d[0]  = id_issue && id_wr_en && (id_dest != '0);
            dest_d[0] = id_dest;
            lat_d[0]  = latNorm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            dest_q <= '0;
            lat_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            dest_q <= dest_d;
            lat_q  <= lat_d;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] stallCnt_q,  stallCnt_d;
    logic [CNT_W-1:0] fwdHitCnt_q, fwdHitCnt_d;

    always_comb begin
        stallCnt_d  = stallCnt_q;
        fwdHitCnt_d = fwdHitCnt_q;
        if (stall && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
        if (id_issue && (|fwd_sel) && (fwdHitCnt_q != '1)) begin
            fwdHitCnt_d = fwdHitCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q  <= '0;
            fwdHitCnt_q <= '0;
        end else begin
            stallCnt_q  <= stallCnt_d;
            fwdHitCnt_q <= fwdHitCnt_d;
        end
    end

    assign stall_cnt   = stallCnt_q;
    assign fwd_hit_cnt = fwdHitCnt_q;
`endif

endmodule

// File: doc/id_fwd_scoreboard.md
Name: id_fwd_scoreboard

Overview:
- Parametrised successor to the ID-stage forwarding logic.
- Holds a shift-register scoreboard of in-flight destination registers, one entry per downstream stage, each with a per-instruction result-ready latency.
- For every ID read port it produces a forward-source select, or a stall when the youngest producer's result is not yet available. This covers ALU, slt/sgt-in-EX, load and multi-cycle producers with one uniform rule.
- Sits between decode and the ID operand/branch-compare muxes.

Parameters:
- REG_AW, 5: register address width.
- DEPTH, 3: tracked stages after ID; stage 1 = EX, stage DEPTH = last stage before register-file write.
- NUM_RD, 2: number of ID read ports.
- SEL_W, $clog2(DEPTH+1): width of each forward select and of the latency field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- id_rd_addr  in  NUM_RD*REG_AW  packed source register addresses; port i is at [i*REG_AW +: REG_AW]
- id_rd_used  in  NUM_RD  port i actually reads its register
- id_wr_en  in  1  ID instruction writes a register
- id_dest  in  REG_AW  ID destination register
- id_lat  in  SEL_W  stage index at whose output the result first exists (1 = EX, e.g. slt/sgt; 2 = load)
- pipe_hold  in  1  downstream freeze
- fwd_sel  out  NUM_RD*SEL_W  per port: 0 = register file, s = forward from stage s
- stall  out  1  ID must hold
- id_issue  out  1  ID instruction advances this cycle

Behaviour:
- State: DEPTH entries, each {vld, dest[REG_AW], lat[SEL_W]}.
- Reset: all vld cleared asynchronously. Counter (if built in) cleared.
- Outputs are combinational from state and inputs; with all entries invalid: fwd_sel = 0, stall = 0.
- Match rule for port i: when id_rd_used[i] and addr != 0, search stages 1..DEPTH for the lowest stage index s with vld && dest == addr.
  - Youngest match wins, even if an older entry is ready.
  - No match: fwd_sel_i = 0.
  - Match with s >= lat: fwd_sel_i = s.
  - Match with s < lat: port is unready; fwd_sel_i = 0.
- stall = id_valid && (any port unready).
- id_issue = id_valid && !stall && !pipe_hold.
- Sequential update:
  - pipe_hold = 1: all entries keep their values.
  - Otherwise, entry k+1 <= entry k for k = 1..DEPTH-1; entry DEPTH retires (its value is in the register file, which is write-before-read).
  - New stage 1 = {1, id_dest, lat'} when id_issue && id_wr_en && id_dest != 0; otherwise a bubble (vld = 0).
- Latency normalisation: lat' = 1 if id_lat == 0; DEPTH if id_lat > DEPTH; else id_lat.
- Stall cycles insert bubbles into stage 1, so the producer advances and the stall resolves after (lat - s) cycles.
- Register 0 is never tracked or matched.
- Both ports matching the same entry: both get the same select.
- ID destination equal to its own source: the match uses existing entries only; the new entry is inserted afterwards.
- Reset mid-stream: all entries are dropped; the next cycle forwards nothing.

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- Defined: adds output stall_cnt (32 bits), incremented on each cycle with stall = 1; saturates at all-ones; cleared by rst. Also adds output fwd_hit_cnt (32 bits), incremented on each cycle where any fwd_sel is non-zero and id_issue = 1; same saturation and reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package: entry struct/field widths, SEL_W computation, constant SEL_RF = 0, latency constants LAT_ALU = 1, LAT_LOAD = 2.
- One sub-module, fwd_port_match: combinational per-port youngest-match and ready check, instantiated NUM_RD times via generate.
- Shift register and counters stay in the top module.

Test Plan:
- Reset held, then released with id_valid = 1, rs = 5 -> fwd_sel = 0, stall = 0, all entries invalid.
- Issue add r5 (lat 1); next cycle ID reads rs = 5 -> fwd_sel0 = 1, no stall. One cycle later -> sel 2; then 3; then 0 (retired).
- Issue lw r7 (lat 2); next cycle ID reads rt = r7 -> stall = 1 for exactly 1 cycle, bubble inserted; following cycle fwd_sel1 = 2, id_issue = 1.
- Stage 1 holds r4 (lat 2) and stage 2 holds r4 (lat 1); ID reads r4 -> stall (youngest unready), not forward from stage 2.
- pipe_hold = 1 for 3 cycles with r9 in stage 1 -> entries frozen, id_issue = 0, fwd_sel for r9 stays 1. Release -> shift resumes.
- Destination r0 issued, then ID reads r0 -> fwd_sel = 0, no stall. With FWD_STALL_CNT_EN defined, the load-use case of scenario 3 -> stall_cnt = 1.
